// File: rtl/legv8_instruction_encoder.sv
// Purpose : packs LEGv8 mnemonic + operand fields into 32-bit words and queues them in a DEPTH-entry FIFO.
// Latency : 1 cycle from request acceptance to instr_valid when empty; no combinational bypass.
// Backpress: req_ready = !full (from count only); pop on instr_valid & instr_ready; optional macro LEGV8_ENC_RANGE_CHECK_EN.
module legv8_instruction_encoder #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_op,
    input  logic [4:0]  req_rd,
    input  logic [4:0]  req_rn,
    input  logic [4:0]  req_rm,
    input  logic [5:0]  req_shamt,
    input  logic [1:0]  req_hw,
    input  logic [25:0] req_imm,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instruction,
    output logic        err,
    output logic [7:0]  err_count
);

    typedef enum logic [3:0] {
        FMT_R, FMT_SHIFT, FMT_BR, FMT_I, FMT_D, FMT_IW,
        FMT_CB, FMT_BCOND, FMT_B, FMT_ILL
    } fmt_t;

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    fmt_t         w_fmt;
    logic [10:0]  w_opc;       // opcode, right-justified
    logic [31:0]  w_word;
    logic         w_range_ok;
    logic         w_reject;
    logic         w_accept;
    logic         w_push;
    logic         w_pop;
    logic         w_full;

    logic [31:0]      r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             r_err;
    logic [7:0]       r_err_count;

    // Decode the mnemonic selector into an opcode and field layout.
    always_comb begin
        w_fmt = FMT_ILL;
        w_opc = 11'd0;
        case (req_op)
            5'd0:  begin w_fmt = FMT_R;     w_opc = 11'b10001011000; end
            5'd1:  begin w_fmt = FMT_R;     w_opc = 11'b11001011000; end
            5'd2:  begin w_fmt = FMT_I;     w_opc = 11'b01001000100; end
            5'd3:  begin w_fmt = FMT_I;     w_opc = 11'b01101000100; end
            5'd4:  begin w_fmt = FMT_R;     w_opc = 11'b10101011000; end
            5'd5:  begin w_fmt = FMT_R;     w_opc = 11'b11101011000; end
            5'd6:  begin w_fmt = FMT_I;     w_opc = 11'b01011000100; end
            5'd7:  begin w_fmt = FMT_I;     w_opc = 11'b01111000100; end
            5'd8:  begin w_fmt = FMT_D;     w_opc = 11'b11111000000; end
            5'd9:  begin w_fmt = FMT_D;     w_opc = 11'b11111000010; end
            5'd10: begin w_fmt = FMT_IW;    w_opc = 11'b00110100101; end
            5'd11: begin w_fmt = FMT_IW;    w_opc = 11'b00111100101; end
            5'd12: begin w_fmt = FMT_R;     w_opc = 11'b10001010000; end
            5'd13: begin w_fmt = FMT_R;     w_opc = 11'b10101010000; end
            5'd14: begin w_fmt = FMT_R;     w_opc = 11'b11001010000; end
            5'd15: begin w_fmt = FMT_I;     w_opc = 11'b01001001000; end
            5'd16: begin w_fmt = FMT_I;     w_opc = 11'b01011001000; end
            5'd17: begin w_fmt = FMT_I;     w_opc = 11'b01101001000; end
            5'd18: begin w_fmt = FMT_R;     w_opc = 11'b11101010000; end
            5'd19: begin w_fmt = FMT_I;     w_opc = 11'b01111001000; end
            5'd20: begin w_fmt = FMT_SHIFT; w_opc = 11'b11010011010; end
            5'd21: begin w_fmt = FMT_SHIFT; w_opc = 11'b11010011011; end
            5'd22: begin w_fmt = FMT_CB;    w_opc = 11'b00010110100; end
            5'd23: begin w_fmt = FMT_CB;    w_opc = 11'b00010110101; end
            5'd24: begin w_fmt = FMT_BCOND; w_opc = 11'b00001010100; end
            5'd25: begin w_fmt = FMT_B;     w_opc = 11'b00000000101; end
            5'd26: begin w_fmt = FMT_BR;    w_opc = 11'b11010110000; end
            5'd27: begin w_fmt = FMT_B;     w_opc = 11'b00000100101; end
            default: begin w_fmt = FMT_ILL; w_opc = 11'd0; end
        endcase
    end

    // Pack operand fields per format; immediates are truncated to field width.
    always_comb begin
        w_word = 32'd0;
        case (w_fmt)
            FMT_R:     w_word = {w_opc, req_rm, req_shamt, req_rn, req_rd};
            FMT_SHIFT: w_word = {w_opc, 5'd0, req_shamt, req_rn, req_rd};
            FMT_BR:    w_word = {w_opc, 5'b11111, 6'd0, req_rn, 5'd0};
            FMT_I:     w_word = {w_opc[9:0], req_imm[11:0], req_rn, req_rd};
            FMT_D:     w_word = {w_opc, req_imm[8:0], 2'b00, req_rn, req_rd};
            FMT_IW:    w_word = {w_opc[8:0], req_hw, req_imm[15:0], req_rd};
            FMT_CB:    w_word = {w_opc[7:0], req_imm[18:0], req_rd};
            FMT_BCOND: w_word = {w_opc[7:0], req_imm[18:0], 1'b0, req_rd[3:0]};
            FMT_B:     w_word = {w_opc[5:0], req_imm};
            default:   w_word = 32'd0;
        endcase
    end

`ifdef LEGV8_ENC_RANGE_CHECK_EN
    // Reject immediates that do not fit their field (signed for D/CB, unsigned for I/IW).
    always_comb begin
        w_range_ok = 1'b1;
        case (w_fmt)
            FMT_I:              w_range_ok = (req_imm[25:12] == 14'd0);
            FMT_IW:             w_range_ok = (req_imm[25:16] == 10'd0);
            FMT_D:              w_range_ok = (&req_imm[25:8]) | ~(|req_imm[25:8]);
            FMT_CB, FMT_BCOND:  w_range_ok = (&req_imm[25:18]) | ~(|req_imm[25:18]);
            default:            w_range_ok = 1'b1;
        endcase
    end
`else
    assign w_range_ok = 1'b1;
`endif

    assign w_full      = (r_count == FULL_CNT);
    assign req_ready   = ~w_full;
    assign w_accept    = req_valid & req_ready;
    assign w_reject    = (w_fmt == FMT_ILL) | ~w_range_ok;
    assign w_push      = w_accept & ~w_reject;
    assign instr_valid = (r_count != '0);
    assign w_pop       = instr_valid & instr_ready;
    assign instruction = instr_valid ? r_mem[r_rd_ptr] : 32'd0;
    assign err         = r_err;
    assign err_count   = r_err_count;

    // Storage array: written at the tail on push; contents are don't-care after reset.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_word;
        end
    end

    // Pointer and occupancy bookkeeping; push and pop together leave count unchanged.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Error pulse one cycle after a rejected acceptance, with a saturating tally.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_err       <= 1'b0;
            r_err_count <= 8'd0;
        end else begin
            r_err <= w_accept & w_reject;
            if (w_accept && w_reject && (r_err_count != 8'hFF)) begin
                r_err_count <= r_err_count + 8'd1;
            end
        end
    end

endmodule

// File: doc/legv8_instruction_encoder.md
Name: legv8_instruction_encoder

Overview:
- Producer-side counterpart to ControlUnit_LEGv8: assembles 32-bit LEGv8 instruction words from mnemonic selector plus operand fields.
- Buffers assembled words in a small FIFO and presents them to the control unit / instruction bus with a valid/ready handshake.
- Used as a self-checking stimulus source and as the back end of the on-chip program loader.

Parameters:
- DEPTH, 4, FIFO entries (power of two, >=2)
- PTR_W, 2, log2(DEPTH)

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  encode request present
- req_ready  out  1  request accepted this cycle when req_valid & req_ready
- req_op  in  5  mnemonic selector (table below)
- req_rd  in  5  Rd/Rt; for B.cond, low 4 bits = cond
- req_rn  in  5  Rn
- req_rm  in  5  Rm
- req_shamt  in  6  shift amount (LSL/LSR)
- req_hw  in  2  MOVZ/MOVK halfword select
- req_imm  in  26  immediate / offset
- instr_valid  out  1  instruction holds a word
- instr_ready  in  1  consumer takes the word when instr_valid & instr_ready
- instruction  out  32  head-of-FIFO word; 32'h0 when empty
- err  out  1  one-cycle pulse, request rejected
- err_count  out  8  saturating count of rejected requests

Behaviour:
- Opcode table, as req_op: opcode bits.
  - R-format: 0 ADD 10001011000; 1 SUB 11001011000; 4 ADDS 10101011000; 5 SUBS 11101011000; 12 AND 10001010000; 13 ORR 10101010000; 14 EOR 11001010000; 18 ANDS 11101010000; 20 LSR 11010011010; 21 LSL 11010011011; 26 BR 11010110000.
  - I-format: 2 ADDI 1001000100; 3 SUBI 1101000100; 6 ADDIS 1011000100; 7 SUBIS 1111000100; 15 ANDI 1001001000; 16 ORRI 1011001000; 17 EORI 1101001000; 19 ANDIS 1111001000.
  - D-format: 8 STUR 11111000000; 9 LDUR 11111000010.
  - IW-format: 10 MOVZ 110100101; 11 MOVK 111100101.
  - CB-format: 22 CBZ 10110100; 23 CBNZ 10110101; 24 B.cond 01010100.
  - B-format: 25 B 000101; 27 BL 100101.
  - 28-31: illegal.
- Field packing:
  - R: op[31:21], rm[20:16], shamt[15:10], rn[9:5], rd[4:0].
  - LSL/LSR force rm=0. BR forces rm=5'b11111, shamt=0, rd=0.
  - I: op[31:22], imm[11:0] at [21:10], rn, rd.
  - D: op[31:21], imm[8:0] at [20:12], 2'b00 at [11:10], rn, rt.
  - IW: op[31:23], hw[22:21], imm[15:0] at [20:5], rd.
  - CB: op[31:24], imm[18:0] at [23:5], rt. B.cond uses rt={1'b0,cond}.
  - B: op[31:26], imm[25:0].
- Handshake:
  - req_ready = !full; it is combinational from the FIFO count only and never depends on req_valid.
  - On acceptance, the encoded word is written to the tail at the clock edge.
  - instr_valid rises the following cycle: latency 1 cycle when empty. There is no combinational bypass.
  - Pop on instr_valid & instr_ready.
  - Simultaneous push and pop when neither full nor empty: count is unchanged and both pointers advance.
  - When full, push is blocked even if a pop occurs that cycle.
  - Pop while empty is a no-op.
- Pointers wrap modulo DEPTH. Count is PTR_W+1 bits, range 0..DEPTH.
- Illegal req_op is accepted (req_ready honoured) but not enqueued. err pulses the cycle after acceptance, and err_count increments, saturating at 255.
- Reset (asynchronous, any time including mid-burst) forces: pointers and count to 0, instr_valid=0, instruction=0, err=0, err_count=0, req_ready=1 after release. FIFO contents are discarded.

Optional Feature:
- Macro: LEGV8_ENC_RANGE_CHECK_EN.
- Defined: requests with an out-of-range immediate are rejected like illegal ops (not enqueued, err pulse, err_count++). Range rules:
  - I: req_imm[25:12] must be 0.
  - IW: req_imm[25:16] must be 0.
  - D: req_imm[25:8] must be all equal (signed 9-bit).
  - CB: req_imm[25:18] must be all equal (signed 19-bit).
  - B/BL: no check.
- Undefined: immediates are silently truncated to field width, and only illegal req_op raises err.

Test Plan:
- ADDI rd=0 rn=0 imm=12'h800, instr_ready=1 -> instruction=32'h91200000 one cycle later; ADDS all-zero fields -> 32'hAB000000.
- ADD rd=0 rn=2 rm=31 -> 32'h8B1F0040. LDUR zeros -> 32'hF8400000. MOVK zeros -> 32'hF2800000. B.cond cond=0 -> 32'h54000000. BL imm=0 -> 32'h94000000.
- DEPTH=4, instr_ready=0, 5 back-to-back requests -> req_ready low after 4th accept. Then instr_ready=1 -> 4 words drained in order, and instr_valid drops after the last pop.
- Full FIFO with push and pop in the same cycle -> pop only, count 4->3, req_ready=1 next cycle.
- req_op=30 -> no enqueue, err=1 for one cycle, err_count=1. With LEGV8_ENC_RANGE_CHECK_EN, ADDI imm=26'h1000 -> rejected, err_count=2. Without it -> enqueued as imm 0.
- Assert reset low with 3 entries queued -> instr_valid=0 and instruction=0 immediately. After release, req_ready=1 and err_count=0.
